// File: rtl/parity_scan_ctrl_if.sv
// ============================================================================
// Module      : parity_scan_ctrl_if
// Description : Bundle between the parity scan controller and its
//               surroundings (ROM + lab-test top level).
//               master : the scan controller. It consumes start/num/parity_in
//                        and drives addr plus the result registers.
//               slave  : the ROM/top-level side.
// Signals     : start      scan request
//               num        ROM data for the current addr
//               parity_in  ROM stored parity bit for the current addr
//               addr       ROM address
//               busy       high while scanning
//               done       one-cycle result-valid pulse
//               err_count  number of failing entries
//               err_mask   per-entry failure flags
//               sum        unsigned sum of scanned data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface parity_scan_ctrl_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic                     start;
    logic [DATA_W-1:0]        num;
    logic                     parity_in;
    logic [ADDR_W-1:0]        addr;
    logic                     busy;
    logic                     done;
    logic [ADDR_W:0]          err_count;
    logic [(2**ADDR_W)-1:0]   err_mask;
    logic [DATA_W+ADDR_W-1:0] sum;

    modport master (
        input  start,
        input  num,
        input  parity_in,
        output addr,
        output busy,
        output done,
        output err_count,
        output err_mask,
        output sum
    );

    modport slave (
        output start,
        output num,
        output parity_in,
        input  addr,
        input  busy,
        input  done,
        input  err_count,
        input  err_mask,
        input  sum
    );
endinterface

`default_nettype wire

// File: rtl/parity_scan_ctrl.sv
// ============================================================================
// Module      : parity_scan_ctrl
// Description : Address sequencer and checker for a parity-protected ROM.
//               On start, walks every address once, checks each entry's
//               stored even-parity bit against its data, counts/flags the
//               failing entries and accumulates the data sum. Results stay
//               readable after done until the next start or reset.
// Ports       : clk    rising-edge clock
//               reset  asynchronous, active-high reset
//               bus    parity_scan_ctrl_if.master (start, num, parity_in in;
//                      addr, busy, done, err_count, err_mask, sum out)
// Options     : `define STOP_ON_ERR_EN -> abort the scan at the first failing
//               entry; addr then holds the failing address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_scan_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  wire                  clk,
    input  wire                  reset,
    parity_scan_ctrl_if.master   bus
);

    localparam int                 C_DEPTH    = 2**ADDR_W;
    localparam int                 C_SUM_W    = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0]  C_LAST     = ADDR_W'(C_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ADDR_W-1:0]      r_addr,      w_addr_nxt;
    logic                   r_busy,      w_busy_nxt;
    logic                   r_done,      w_done_nxt;
    logic [ADDR_W:0]        r_err_count, w_err_count_nxt;
    logic [C_DEPTH-1:0]     r_err_mask,  w_err_mask_nxt;
    logic [C_SUM_W-1:0]     r_sum,       w_sum_nxt;

    // Even parity: an entry is good when its stored bit equals the XOR of
    // its data bits.
    logic                   w_fail;
    assign w_fail = (bus.parity_in != (^bus.num));

    // ------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_count <= '0;
            r_err_mask  <= '0;
            r_sum       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err_count <= w_err_count_nxt;
            r_err_mask  <= w_err_mask_nxt;
            r_sum       <= w_sum_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Everything holds by default so
    // results stay readable in IDLE; num/parity_in are only looked at
    // in SCAN.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_err_count_nxt = r_err_count;
        w_err_mask_nxt  = r_err_mask;
        w_sum_nxt       = r_sum;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_addr_nxt      = '0;
                    w_err_count_nxt = '0;
                    w_err_mask_nxt  = '0;
                    w_sum_nxt       = '0;
                    w_busy_nxt      = 1'b1;
                    w_state_nxt     = S_SCAN;
                end
            end

            S_SCAN: begin
                // Sum width leaves room for DEPTH full-scale values.
                w_sum_nxt = r_sum + {{ADDR_W{1'b0}}, bus.num};
                if (w_fail) begin
                    w_err_count_nxt         = r_err_count + (ADDR_W+1)'(1);
                    w_err_mask_nxt[r_addr]  = 1'b1;
                end
`ifdef STOP_ON_ERR_EN
                if (w_fail) begin
                    // Leave addr on the offending entry for inspection.
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_addr_nxt = r_addr + ADDR_W'(1);
                    if (r_addr == C_LAST) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
`else
                // Natural wrap brings addr back to 0 after the last entry.
                w_addr_nxt = r_addr + ADDR_W'(1);
                if (r_addr == C_LAST) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end
`endif
            end

            S_DONE: begin
                // start is deliberately ignored here; a held start is
                // picked up on the following IDLE edge.
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.addr      = r_addr;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err_count = r_err_count;
    assign bus.err_mask  = r_err_mask;
    assign bus.sum       = r_sum;

endmodule

`default_nettype wire
